// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with pause/resume, one-cycle done pulse on expiry
// and optional auto-reload for periodic operation.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] P,
  output logic             running,
  output logic             expired,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Priority: load > pause > start > tick (reset handled in the register).
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (count_q != ZERO)) state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else begin
              // Zero is only ever reached through this expiry path.
              done_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = ZERO;
                state_d = EXPIRED;
              end
            end
          end
        end
        PAUSED: begin
          if (!pause && start) state_d = RUN;
        end
        EXPIRED: begin
          if (start) begin
            count_d = reload_q;
            if (reload_q != ZERO) state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign P       = count_q;
  assign running = (state_q == RUN);
  assign expired = (state_q == EXPIRED);
  assign done    = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH=4).
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset, tick, load, start, pause, auto_reload;
  logic [3:0] load_value;
  logic [3:0] P;
  logic       running, expired, done;

  int checks   = 0;
  int failures = 0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .load_value(load_value), .start(start), .pause(pause),
    .auto_reload(auto_reload), .P(P), .running(running),
    .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_value = 4'(v);
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int p_exp;
  logic tk;

  initial begin
    reset = 1'b1; tick = 0; load = 0; start = 0; pause = 0;
    auto_reload = 0; load_value = '0;
    step();
    $display("reset: P=%0d running=%0d expired=%0d done=%0d", P, running, expired, done);
    check("rst_P", P, 0);
    check("rst_running", running, 0);
    check("rst_expired", expired, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    // Reset during RUN with P=9
    do_load(9);
    do_start();
    check("pre_rst_running", running, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("reset mid-run: P=%0d running=%0d done=%0d", P, running, done);
    check("midrst_P", P, 0);
    check("midrst_running", running, 0);
    check("midrst_done", done, 0);

    // One-shot count from 5
    do_load(5);
    check("os_load_P", P, 5);
    do_start();
    check("os_start_running", running, 1);
    check("os_start_P", P, 5);
    tick = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      step();
      $display("oneshot: P=%0d done=%0d", P, done);
      check("os_P", P, i);
      check("os_done", done, 0);
    end
    step();
    $display("oneshot expiry: P=%0d done=%0d expired=%0d", P, done, expired);
    check("os_exp_P", P, 0);
    check("os_exp_done", done, 1);
    check("os_exp_expired", expired, 1);
    check("os_exp_running", running, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("os_hold_P", P, 0);
      check("os_hold_done", done, 0);
      check("os_hold_expired", expired, 1);
    end
    tick = 1'b0;

    // Auto-reload from 3
    auto_reload = 1'b1;
    do_load(3);
    do_start();
    tick = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      $display("autoreload: tick %0d P=%0d done=%0d", k, P, done);
      check("ar_P", P, 3 - (k % 3));
      check("ar_done", done, (k % 3 == 0) ? 1 : 0);
      check("ar_expired", expired, 0);
    end
    tick = 1'b0;
    auto_reload = 1'b0;

    // Pause / resume from 15
    do_load(15);
    do_start();
    tick = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("pz_P11", P, 11);
    pause = 1'b1;
    step();
    pause = 1'b0;
    $display("pause: P=%0d running=%0d", P, running);
    check("pz_P", P, 11);
    check("pz_running", running, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("pz_hold_P", P, 11);
    end
    tick = 1'b0;
    do_start();
    check("resume_running", running, 1);
    check("resume_P", P, 11);
    tick = 1'b1;
    step();
    check("resume_P10", P, 10);
    step();
    check("resume_P9", P, 9);
    tick = 1'b0;
    pause = 1'b1;
    step();
    check("pz2_running", running, 0);
    start = 1'b1;
    step();
    pause = 1'b0; start = 1'b0;
    $display("pause+start while paused: P=%0d running=%0d", P, running);
    check("pzst_running", running, 0);
    check("pzst_P", P, 9);

    // Tick gating: tick every third cycle from 4
    do_load(4);
    do_start();
    p_exp = 4;
    for (int c = 0; c < 12; c++) begin
      tk = (c % 3 == 2);
      tick = tk;
      step();
      if (tk) p_exp--;
      $display("gating: cycle %0d tick=%0d P=%0d done=%0d", c, tk, P, done);
      check("gate_P", P, p_exp);
      check("gate_done", done, (tk && p_exp == 0) ? 1 : 0);
    end
    tick = 1'b0;
    check("gate_expired", expired, 1);

    // load 0 then start: stays IDLE
    do_load(0);
    do_start();
    check("z_running", running, 0);
    check("z_done", done, 0);
    check("z_expired", expired, 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("z_tick_P", P, 0);
    check("z_tick_running", running, 0);

    // Restart from EXPIRED with reload 2
    do_load(2);
    do_start();
    tick = 1'b1;
    step(); step();
    tick = 1'b0;
    check("ex_done1", done, 1);
    check("ex_expired1", expired, 1);
    do_start();
    $display("restart from expired: P=%0d running=%0d expired=%0d", P, running, expired);
    check("ex_restart_P", P, 2);
    check("ex_restart_running", running, 1);
    check("ex_restart_expired", expired, 0);
    tick = 1'b1;
    step();
    check("ex_P1", P, 1);
    step();
    tick = 1'b0;
    check("ex_done2", done, 1);
    check("ex_expired2", expired, 1);
    do_load(2);
    check("ex_load_expired", expired, 0);
    check("ex_load_P", P, 2);

    // Load during RUN wins over same-cycle tick and start
    do_start();
    tick = 1'b1;
    step();
    check("lr_P1", P, 1);
    load = 1'b1; load_value = 4'd7; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0; tick = 1'b0;
    $display("load during run: P=%0d running=%0d done=%0d", P, running, done);
    check("lr_P", P, 7);
    check("lr_running", running, 0);
    check("lr_done", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counter/timer; the counting-down complement of the team's 4-bit free-running up-counter.
- Software or board logic loads a start value, starts the count and may pause or resume it.
- Raises a one-cycle done pulse on reaching zero; optionally auto-reloads for periodic operation.
- Feeds board-level timing, e.g. countdown display on 7-segment and periodic event generation.

Parameters:
- WIDTH, 4, counter width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  count enable strobe (e.g. from prescaler); decrement only on cycles with tick=1.
- load  input  1  load strobe; captures load_value.
- load_value  input  WIDTH  start/reload value.
- start  input  1  start from IDLE, resume from PAUSED, restart from EXPIRED.
- pause  input  1  pause request while RUN.
- auto_reload  input  1  1 = reload on expiry and keep running; 0 = stop at zero.
- P  output  WIDTH  current count, registered.
- running  output  1  high while state is RUN.
- expired  output  1  high while state is EXPIRED.
- done  output  1  registered one-cycle pulse on each expiry.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
  - Reset values: P=0, reload register=0, state IDLE, running=0, expired=0, done=0.
  - Reset mid-count aborts immediately; no done pulse.
- Priority each cycle: reset > load > pause > start > tick.
- done defaults to 0 every cycle unless set by an expiry event below.
- load (any state): P<=load_value, reload_reg<=load_value, state<=IDLE. A same-cycle start/tick is ignored.
- State IDLE:
  - start=1 and P!=0 -> RUN next cycle; the first decrement needs a later tick.
  - start with P==0 is ignored.
- State RUN:
  - pause=1 -> PAUSED, P held; a same-cycle tick is dropped.
  - tick=1 and P>1: P<=P-1.
  - tick=1 and P==1: done<=1 for that edge only.
    - auto_reload=1: P<=reload_reg, stay RUN.
    - auto_reload=0: P<=0, state<=EXPIRED.
  - auto_reload is sampled at the expiry edge.
- State PAUSED:
  - P held; tick ignored.
  - start=1 -> RUN; pause and start in the same cycle -> stays PAUSED.
- State EXPIRED:
  - P=0 held, expired=1.
  - start=1: P<=reload_reg, state<=RUN if reload_reg!=0, else stays EXPIRED.
- Arithmetic:
  - Unsigned WIDTH bits; P never underflows, since 0 is only reached via the P==1 expiry path.
  - Max load 2^WIDTH-1 (15 at default).
- running and expired are decoded directly from the state register (no extra latency). done is registered.
- With reload value 1 and auto_reload=1, done pulses on every tick.

Test Plan:
- Reset during RUN with P=9 -> next cycle P=0, IDLE, running=0, done=0.
- load 5, start, tick held high, auto_reload=0:
  - P sequence 5,4,3,2,1,0.
  - done high exactly the cycle P becomes 0.
  - expired=1 afterwards, P stays 0 with further ticks.
- load 3, auto_reload=1, start, continuous tick:
  - P 3,2,1,3,2,1,...
  - done pulses every 3rd tick, expired stays 0.
- load 15, start, 4 ticks (P=11), pause together with a tick:
  - P stays 11 for 10 ticks.
  - start -> count resumes 10,9,...
  - pause+start in the same cycle while PAUSED -> remains PAUSED.
- tick gating: load 4, start, tick every 3rd cycle -> P decrements only on tick cycles; done after 4 ticks.
- Corner cases:
  - load 0 then start -> stays IDLE, no done.
  - In EXPIRED after load 2, start -> P=2, RUN, expires again after 2 ticks.
  - load asserted during RUN with value 7 -> P=7, IDLE.
